// File: rtl/ifu_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifu_fetch_if : instruction-memory, core-output and redirect signal bundle |
// | Revision     : 1.0                                                        |
// +----------------------------------------------------------------------------+
interface ifu_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, out_err,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, out_err,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           out_ready, redirect_valid, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifu_fetch : credit-limited in-order instruction fetch with redirect kill   |
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+
module ifu_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  ifu_fetch_if.master  bus
);

  localparam int              c_PW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int              c_CW   = $clog2(BUF_DEPTH + 1);
  localparam logic [c_PW-1:0] c_LAST = c_PW'(BUF_DEPTH - 1);

  function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
    return (p == c_LAST) ? '0 : p + c_PW'(1);
  endfunction

  // Request channel state
  logic                 r_req_valid;
  logic [63:0]          r_req_addr;
  logic                 r_req_kill;
  logic [63:0]          r_fetch_pc;

  // In-flight tag queue
  logic [63:0]          r_tq_addr [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] r_tq_kill;
  logic [c_PW-1:0]      r_tq_wr;
  logic [c_PW-1:0]      r_tq_rd;
  logic [c_CW-1:0]      r_tq_cnt;

  // Instruction buffer
  logic [31:0]          r_buf_inst [BUF_DEPTH];
  logic [63:0]          r_buf_pc   [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] r_buf_err;
  logic [c_PW-1:0]      r_buf_wr;
  logic [c_PW-1:0]      r_buf_rd;
  logic [c_CW-1:0]      r_buf_cnt;

  logic                 w_req_hs;
  logic                 w_rsp_pop;
  logic                 w_buf_push;
  logic                 w_buf_pop;
  logic [c_CW:0]        w_credit_sum;
  logic                 w_credit;
  logic                 w_issue;
  logic                 w_req_kill_nxt;
  logic [63:0]          w_fetch_pc_nxt;

  assign w_req_hs   = r_req_valid & bus.imem_req_ready;
  assign w_rsp_pop  = bus.imem_rsp_valid & (r_tq_cnt != '0);
  assign w_buf_push = w_rsp_pop & ~r_tq_kill[r_tq_rd] & ~bus.redirect_valid;
  assign w_buf_pop  = (r_buf_cnt != '0) & bus.out_ready & ~bus.redirect_valid;

  // Killed entries still occupy the tag queue, so they keep holding credit.
  assign w_credit_sum = {1'b0, r_tq_cnt} + {1'b0, r_buf_cnt} + (c_CW+1)'(r_req_valid);
  assign w_credit     = w_credit_sum < (c_CW+1)'(BUF_DEPTH);
  assign w_issue      = (~r_req_valid | w_req_hs) & w_credit;

  assign w_req_kill_nxt = r_req_valid & ~w_req_hs & (r_req_kill | bus.redirect_valid);

  // A killed pending request already left fetch_pc at the redirect target.
  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    if (bus.redirect_valid)
      w_fetch_pc_nxt = {bus.redirect_pc[63:2], 2'b00};
    else if (w_req_hs && !r_req_kill)
      w_fetch_pc_nxt = r_fetch_pc + 64'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_kill  <= 1'b0;
      r_fetch_pc  <= RESET_PC;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_kill <= w_req_kill_nxt;
      if (w_issue) begin
        r_req_valid <= 1'b1;
        r_req_addr  <= w_fetch_pc_nxt;
      end else if (w_req_hs) begin
        r_req_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_tq_addr[i] <= '0;
      r_tq_kill <= '0;
      r_tq_wr   <= '0;
      r_tq_rd   <= '0;
      r_tq_cnt  <= '0;
    end else begin
      if (bus.redirect_valid)
        r_tq_kill <= '1;
      if (w_req_hs) begin
        r_tq_addr[r_tq_wr] <= r_req_addr;
        r_tq_kill[r_tq_wr] <= r_req_kill | bus.redirect_valid;
        r_tq_wr            <= ptr_inc(r_tq_wr);
      end
      if (w_rsp_pop)
        r_tq_rd <= ptr_inc(r_tq_rd);
      case ({w_req_hs, w_rsp_pop})
        2'b10:   r_tq_cnt <= r_tq_cnt + c_CW'(1);
        2'b01:   r_tq_cnt <= r_tq_cnt - c_CW'(1);
        default: r_tq_cnt <= r_tq_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_inst[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
      r_buf_err <= '0;
      r_buf_wr  <= '0;
      r_buf_rd  <= '0;
      r_buf_cnt <= '0;
    end else if (bus.redirect_valid) begin
      r_buf_wr  <= '0;
      r_buf_rd  <= '0;
      r_buf_cnt <= '0;
    end else begin
      if (w_buf_push) begin
        r_buf_inst[r_buf_wr] <= bus.imem_rsp_data;
        r_buf_pc[r_buf_wr]   <= r_tq_addr[r_tq_rd];
        r_buf_err[r_buf_wr]  <= bus.imem_rsp_err;
        r_buf_wr             <= ptr_inc(r_buf_wr);
      end
      if (w_buf_pop)
        r_buf_rd <= ptr_inc(r_buf_rd);
      case ({w_buf_push, w_buf_pop})
        2'b10:   r_buf_cnt <= r_buf_cnt + c_CW'(1);
        2'b01:   r_buf_cnt <= r_buf_cnt - c_CW'(1);
        default: r_buf_cnt <= r_buf_cnt;
      endcase
    end
  end

  assign bus.imem_req_valid = r_req_valid;
  assign bus.imem_req_addr  = r_req_addr;
  assign bus.out_valid      = (r_buf_cnt != '0);
  assign bus.out_inst       = r_buf_inst[r_buf_rd];
  assign bus.out_pc         = r_buf_pc[r_buf_rd];
  assign bus.out_err        = r_buf_err[r_buf_rd];

endmodule
`default_nettype wire
